dual_wb_stage: RTL and testbench

- Writeback stage of the 2-way superscalar core, directly upstream of the register file write ports.
- Registers the two retiring results of one issue bundle (lane 1 older, lane 2 younger).
- Suppresses x0 writes and resolves same-destination collisions.
- Serializes the bundle onto a single write port when so configured, and supplies bypass data for the four source-operand reads of the next bundle.

---
 rtl/dual_wb_pkg.sv | 24 ++
 rtl/dual_wb_stage_fwd_match.sv | 30 +++
 rtl/dual_wb_stage.sv | 155 +++++++++++++++
 tb/tb_dual_wb_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_wb_pkg.sv
// Shared types for the dual-lane writeback stage: the lane record, the
// serializer state and the "does this lane really write" predicate.
package dual_wb_pkg;

  localparam int XLEN_DEF = 64;
  localparam int AW_DEF   = 5;

  typedef struct packed {
    logic                wen;
    logic [AW_DEF-1:0]   rd;
    logic [XLEN_DEF-1:0] data;
  } wb_lane_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } wb_state_t;

  // x0 is hardwired to zero, so a write to it is never issued.
  function automatic logic is_effective(input wb_lane_t lane);
    return lane.wen && (lane.rd != '0);
  endfunction

endpackage

// File: rtl/dual_wb_stage_fwd_match.sv
// One bypass query against a small set of in-flight writes; candidate 0 is
// the newest and wins over higher indices.
module fwd_match #(
  parameter int XLEN     = 64,
  parameter int AW       = 5,
  parameter int NUM_CAND = 3
) (
  input  logic [AW-1:0]                     q_addr,
  input  logic [NUM_CAND-1:0]               cand_wen,
  input  logic [NUM_CAND-1:0][AW-1:0]       cand_rd,
  input  logic [NUM_CAND-1:0][XLEN-1:0]     cand_data,
  output logic                              hit,
  output logic [XLEN-1:0]                   data
);

  // Walk from oldest to newest so the newest match overwrites the others.
  // NOTE: every always_comb output gets a default first, otherwise a path
  // with no match would infer a latch.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = NUM_CAND - 1; i >= 0; i--) begin
      if ((q_addr != '0) && cand_wen[i] && (cand_rd[i] == q_addr)) begin
        hit  = 1'b1;
        data = cand_data[i];
      end
    end
  end

endmodule

// File: rtl/dual_wb_stage.sv
// Writeback stage for the 2-way core: registers both lane results, drops x0
// and WAW-shadowed writes, optionally serializes onto one port, and bypasses.
module dual_wb_stage
  import dual_wb_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int AW         = AW_DEF,
  parameter int NUM_WPORTS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_wen1,
  input  logic [AW-1:0]   in_rd1,
  input  logic [XLEN-1:0] in_data1,
  input  logic            in_wen2,
  input  logic [AW-1:0]   in_rd2,
  input  logic [XLEN-1:0] in_data2,
  output logic            Wen1,
  output logic [AW-1:0]   Rd_addr1,
  output logic [XLEN-1:0] write_data1,
  output logic            Wen2,
  output logic [AW-1:0]   Rd_addr2,
  output logic [XLEN-1:0] write_data2,
  input  logic [AW-1:0]   q_addr0,
  input  logic [AW-1:0]   q_addr1,
  input  logic [AW-1:0]   q_addr2,
  input  logic [AW-1:0]   q_addr3,
  output logic            fwd_hit0,
  output logic            fwd_hit1,
  output logic            fwd_hit2,
  output logic            fwd_hit3,
  output logic [XLEN-1:0] fwd_data0,
  output logic [XLEN-1:0] fwd_data1,
  output logic [XLEN-1:0] fwd_data2,
  output logic [XLEN-1:0] fwd_data3
);

  wb_state_t state_q, state_d;
  wb_lane_t  p1_q, p1_d, p2_q, p2_d, pend_q, pend_d;
  wb_lane_t  lane1, lane2;
  logic      eff1, eff2, accept, split;

  always_comb begin
    lane1  = '{wen: in_wen1, rd: in_rd1, data: in_data1};
    lane2  = '{wen: in_wen2, rd: in_rd2, data: in_data2};
    eff2   = is_effective(lane2);
    // The younger lane shadows the older one when both target the same reg.
    eff1   = is_effective(lane1) && !(eff2 && (in_rd1 == in_rd2));
    accept = in_valid && in_ready;
    split  = (NUM_WPORTS == 1) && eff1 && eff2;
  end

  // NOTE: state is updated with non-blocking assignments only, and the
  // synchronous reset clears every flop including the pending entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p1_q    <= '0;
      p2_q    <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && split) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address/data hold between writes; only the enable drops.
  always_comb begin
    p1_d     = p1_q;
    p1_d.wen = 1'b0;
    p2_d     = p2_q;
    p2_d.wen = 1'b0;
    pend_d   = pend_q;
    if (NUM_WPORTS == 1) begin
      p2_d = '0;
      if (state_q == DRAIN) begin
        p1_d   = pend_q;
        pend_d = '0;
      end else if (accept) begin
        if (eff1) begin
          p1_d = lane1;
        end else if (eff2) begin
          p1_d = lane2;
        end
        if (split) begin
          pend_d = lane2;
        end
      end
    end else if (accept) begin
      if (eff1) p1_d = lane1;
      if (eff2) p2_d = lane2;
    end
  end

  always_comb begin
    in_ready    = !rst && (state_q == IDLE);
    Wen1        = p1_q.wen;
    Rd_addr1    = p1_q.rd;
    write_data1 = p1_q.data;
    Wen2        = p2_q.wen;
    Rd_addr2    = p2_q.rd;
    write_data2 = p2_q.data;
  end

  logic [3:0][AW-1:0]   q_addr;
  logic [3:0]           hit_vec;
  logic [3:0][XLEN-1:0] data_vec;
  logic [2:0]           cand_wen;
  logic [2:0][AW-1:0]   cand_rd;
  logic [2:0][XLEN-1:0] cand_data;

  // Priority: pending (newest) > port 2 > port 1.
  assign q_addr    = {q_addr3, q_addr2, q_addr1, q_addr0};
  assign cand_wen  = {p1_q.wen, p2_q.wen, pend_q.wen && (state_q == DRAIN)};
  assign cand_rd   = {p1_q.rd, p2_q.rd, pend_q.rd};
  assign cand_data = {p1_q.data, p2_q.data, pend_q.data};

  for (genvar g = 0; g < 4; g++) begin : g_fwd
    fwd_match #(
      .XLEN     (XLEN),
      .AW       (AW),
      .NUM_CAND (3)
    ) u_match (
      .q_addr    (q_addr[g]),
      .cand_wen  (cand_wen),
      .cand_rd   (cand_rd),
      .cand_data (cand_data),
      .hit       (hit_vec[g]),
      .data      (data_vec[g])
    );
  end

  assign fwd_hit0  = hit_vec[0];
  assign fwd_hit1  = hit_vec[1];
  assign fwd_hit2  = hit_vec[2];
  assign fwd_hit3  = hit_vec[3];
  assign fwd_data0 = data_vec[0];
  assign fwd_data1 = data_vec[1];
  assign fwd_data2 = data_vec[2];
  assign fwd_data3 = data_vec[3];

endmodule

// File: tb/tb_dual_wb_stage.sv
// Directed bench for dual_wb_stage: one 2-port and one 1-port instance share
// lane inputs; expected port activity is queued on drive and popped on check.
module tb_dual_wb_stage;

  localparam int XLEN = 64;
  localparam int AW   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst1, rst2, v1, v2;
  logic            wen1, wen2;
  logic [AW-1:0]   rd1, rd2;
  logic [XLEN-1:0] d1, d2;
  logic [AW-1:0]   qa0, qa1, qa2, qa3;

  logic            rdy2, w1_2, w2_2, rdy1, w1_1, w2_1;
  logic [AW-1:0]   a1_2, a2_2, a1_1, a2_1;
  logic [XLEN-1:0] wd1_2, wd2_2, wd1_1, wd2_1;
  logic [3:0]      hit2, hit1;
  logic [XLEN-1:0] fd2 [4];
  logic [XLEN-1:0] fd1 [4];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic            w1;
    logic [AW-1:0]   a1;
    logic [XLEN-1:0] d1;
    logic            w2;
    logic [AW-1:0]   a2;
    logic [XLEN-1:0] d2;
  } exp_t;

  exp_t sb2[$];
  exp_t sb1[$];
  exp_t m2;

  dual_wb_stage #(.XLEN(XLEN), .AW(AW), .NUM_WPORTS(2)) dut2 (
    .clk(clk), .rst(rst2), .in_valid(v2), .in_ready(rdy2),
    .in_wen1(wen1), .in_rd1(rd1), .in_data1(d1),
    .in_wen2(wen2), .in_rd2(rd2), .in_data2(d2),
    .Wen1(w1_2), .Rd_addr1(a1_2), .write_data1(wd1_2),
    .Wen2(w2_2), .Rd_addr2(a2_2), .write_data2(wd2_2),
    .q_addr0(qa0), .q_addr1(qa1), .q_addr2(qa2), .q_addr3(qa3),
    .fwd_hit0(hit2[0]), .fwd_hit1(hit2[1]), .fwd_hit2(hit2[2]), .fwd_hit3(hit2[3]),
    .fwd_data0(fd2[0]), .fwd_data1(fd2[1]), .fwd_data2(fd2[2]), .fwd_data3(fd2[3])
  );

  dual_wb_stage #(.XLEN(XLEN), .AW(AW), .NUM_WPORTS(1)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(v1), .in_ready(rdy1),
    .in_wen1(wen1), .in_rd1(rd1), .in_data1(d1),
    .in_wen2(wen2), .in_rd2(rd2), .in_data2(d2),
    .Wen1(w1_1), .Rd_addr1(a1_1), .write_data1(wd1_1),
    .Wen2(w2_1), .Rd_addr2(a2_1), .write_data2(wd2_1),
    .q_addr0(qa0), .q_addr1(qa1), .q_addr2(qa2), .q_addr3(qa3),
    .fwd_hit0(hit1[0]), .fwd_hit1(hit1[1]), .fwd_hit2(hit1[2]), .fwd_hit3(hit1[3]),
    .fwd_data0(fd1[0]), .fwd_data1(fd1[1]), .fwd_data2(fd1[2]), .fwd_data3(fd1[3])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic w1i, input logic [AW-1:0] r1i, input logic [XLEN-1:0] d1i,
                        input logic w2i, input logic [AW-1:0] r2i, input logic [XLEN-1:0] d2i);
    wen1 = w1i; rd1 = r1i; d1 = d1i;
    wen2 = w2i; rd2 = r2i; d2 = d2i;
  endtask

  // Reference for the 2-port instance: what the ports show after the next edge.
  task automatic push2(input logic accepted);
    exp_t e;
    logic e1, e2;
    e1 = accepted && wen1 && (rd1 != '0);
    e2 = accepted && wen2 && (rd2 != '0);
    if (e1 && e2 && (rd1 == rd2)) e1 = 1'b0;
    e.w1 = e1; e.a1 = e1 ? rd1 : m2.a1; e.d1 = e1 ? d1 : m2.d1;
    e.w2 = e2; e.a2 = e2 ? rd2 : m2.a2; e.d2 = e2 ? d2 : m2.d2;
    m2 = e;
    sb2.push_back(e);
  endtask

  task automatic push1(input logic w, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    exp_t e;
    e = '{w1: w, a1: a, d1: d, w2: 1'b0, a2: '0, d2: '0};
    sb1.push_back(e);
  endtask

  task automatic check_sb(input int which, input string tag);
    exp_t e;
    if ((which == 2) ? (sb2.size() == 0) : (sb1.size() == 0)) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty, observed nothing expected an entry", tag);
      return;
    end
    if (which == 2) begin
      e = sb2.pop_front();
      check({tag, ".Wen1"}, 64'(w1_2), 64'(e.w1));
      check({tag, ".Rd_addr1"}, 64'(a1_2), 64'(e.a1));
      check({tag, ".write_data1"}, wd1_2, e.d1);
      check({tag, ".Wen2"}, 64'(w2_2), 64'(e.w2));
      check({tag, ".Rd_addr2"}, 64'(a2_2), 64'(e.a2));
      check({tag, ".write_data2"}, wd2_2, e.d2);
    end else begin
      e = sb1.pop_front();
      check({tag, ".Wen1"}, 64'(w1_1), 64'(e.w1));
      check({tag, ".Rd_addr1"}, 64'(a1_1), 64'(e.a1));
      check({tag, ".write_data1"}, wd1_1, e.d1);
      check({tag, ".Wen2"}, 64'(w2_1), 64'(e.w2));
      check({tag, ".Rd_addr2"}, 64'(a2_1), 64'(e.a2));
      check({tag, ".write_data2"}, wd2_1, e.d2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  logic [XLEN-1:0] rx, ry;

  initial begin
    m2   = '{w1: 1'b0, a1: '0, d1: '0, w2: 1'b0, a2: '0, d2: '0};
    rst1 = 1'b1; rst2 = 1'b1; v1 = 1'b0; v2 = 1'b0;
    qa0 = '0; qa1 = '0; qa2 = '0; qa3 = '0;
    set_in(1'b0, '0, '0, 1'b0, '0, '0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.ready2", 64'(rdy2), 64'd0);
    check("rst.ready1", 64'(rdy1), 64'd0);
    check("rst.Wen1_2", 64'(w1_2), 64'd0);
    check("rst.Wen2_2", 64'(w2_2), 64'd0);
    check("rst.addr1_2", 64'(a1_2), 64'd0);
    check("rst.data2_2", wd2_2, 64'd0);
    check("rst.Wen1_1", 64'(w1_1), 64'd0);
    rst1 = 1'b0; rst2 = 1'b0;
    #1;
    check("post_rst.ready2", 64'(rdy2), 64'd1);
    check("post_rst.ready1", 64'(rdy1), 64'd1);

    // 2-port: two independent lanes
    set_in(1'b1, 5'd5, 64'h11, 1'b1, 5'd6, 64'h22);
    v2 = 1'b1; push2(1'b1);
    tick();
    v2 = 1'b0; push2(1'b0);
    check_sb(2, "two_lane");
    tick();
    check_sb(2, "two_lane_idle");

    // WAW: only lane 2 survives, and it is visible to the bypass
    set_in(1'b1, 5'd9, 64'hAA, 1'b1, 5'd9, 64'hBB);
    v2 = 1'b1; push2(1'b1);
    tick();
    v2 = 1'b0; push2(1'b0);
    check_sb(2, "waw");
    qa0 = 5'd9; qa1 = 5'd5; qa2 = 5'd0; #1;
    check("waw.fwd_hit0", 64'(hit2[0]), 64'd1);
    check("waw.fwd_data0", fd2[0], 64'hBB);
    check("waw.stale_hit1", 64'(hit2[1]), 64'd0);
    check("waw.zero_hit2", 64'(hit2[2]), 64'd0);
    tick();
    check_sb(2, "waw_idle");

    // x0 suppression and a non-writing lane
    set_in(1'b1, 5'd0, 64'h77, 1'b0, 5'd7, 64'h88);
    v2 = 1'b1; push2(1'b1);
    tick();
    v2 = 1'b0; push2(1'b0);
    check_sb(2, "x0");
    qa3 = 5'd0; qa0 = 5'd7; #1;
    check("x0.fwd_hit3", 64'(hit2[3]), 64'd0);
    check("x0.fwd_data3", fd2[3], 64'd0);
    check("x0.fwd_hit0", 64'(hit2[0]), 64'd0);
    tick();
    check_sb(2, "x0_idle");

    // Back-to-back 2-port bundles
    for (int i = 0; i < 8; i++) begin
      rx = {$urandom, $urandom};
      ry = {$urandom, $urandom};
      set_in(1'b1, 5'(10 + i), rx, 1'b1, 5'(20 + i), ry);
      v2 = 1'b1; push2(1'b1);
      tick();
      check_sb(2, $sformatf("b2b%0d", i));
      qa0 = 5'(10 + i); qa1 = 5'(20 + i); #1;
      check($sformatf("b2b%0d.fwd_data0", i), fd2[0], rx);
      check($sformatf("b2b%0d.fwd_data1", i), fd2[1], ry);
    end
    v2 = 1'b0; push2(1'b0);
    tick();
    check_sb(2, "b2b_end");

    // 1-port: split into two consecutive writes
    check("drain.ready_pre", 64'(rdy1), 64'd1);
    set_in(1'b1, 5'd3, 64'h456701023D2, 1'b1, 5'd4, 64'h12005C2);
    v1 = 1'b1;
    push1(1'b1, 5'd3, 64'h456701023D2);
    push1(1'b1, 5'd4, 64'h12005C2);
    push1(1'b0, 5'd4, 64'h12005C2);
    tick();
    v1 = 1'b0;
    check_sb(1, "drain_n1");
    check("drain_n1.ready", 64'(rdy1), 64'd0);
    qa0 = 5'd4; qa1 = 5'd3; #1;
    check("drain_n1.fwd_hit0", 64'(hit1[0]), 64'd1);
    check("drain_n1.fwd_data0", fd1[0], 64'h12005C2);
    check("drain_n1.fwd_data1", fd1[1], 64'h456701023D2);
    tick();
    check_sb(1, "drain_n2");
    #1;
    check("drain_n2.fwd_data0", fd1[0], 64'h12005C2);
    check("drain_n2.fwd_hit1", 64'(hit1[1]), 64'd0);
    tick();
    check_sb(1, "drain_n3");
    check("drain_n3.ready", 64'(rdy1), 64'd1);

    // 1-port WAW collapses to a single write with no drain
    set_in(1'b1, 5'd8, 64'hAA, 1'b1, 5'd8, 64'hBB);
    v1 = 1'b1;
    push1(1'b1, 5'd8, 64'hBB);
    push1(1'b0, 5'd8, 64'hBB);
    tick();
    v1 = 1'b0;
    check_sb(1, "waw1");
    check("waw1.ready", 64'(rdy1), 64'd1);
    tick();
    check_sb(1, "waw1_idle");

    // 1-port: reset during DRAIN discards the pending lane
    set_in(1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'h44);
    v1 = 1'b1;
    push1(1'b1, 5'd3, 64'h33);
    tick();
    v1 = 1'b0;
    check_sb(1, "rst_drain_n1");
    rst1 = 1'b1; #1;
    check("rst_drain.ready_in_rst", 64'(rdy1), 64'd0);
    push1(1'b0, 5'd0, 64'd0);
    tick();
    check_sb(1, "rst_drain_n2");
    check("rst_drain.ready_held", 64'(rdy1), 64'd0);
    rst1 = 1'b0;
    push1(1'b0, 5'd0, 64'd0);
    tick();
    check_sb(1, "rst_drain_n3");
    check("rst_drain.ready_after", 64'(rdy1), 64'd1);
    set_in(1'b1, 5'd12, 64'hC, 1'b0, 5'd0, 64'd0);
    v1 = 1'b1;
    push1(1'b1, 5'd12, 64'hC);
    tick();
    v1 = 1'b0;
    check_sb(1, "rst_drain_idle");
    check("rst_drain_idle.ready", 64'(rdy1), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
